tc_rom_streamer: RTL and testbench
==================================

# tc_rom_streamer

Sequencer that sits directly upstream of the file ROM and downstream of nothing but a start pulse: it drives the ROM's enable/address, reads the file size from the ROM's size slot (address all-ones), then fetches 64-bit words and emits the file as a little-endian byte stream over a valid/ready handshake. Typical consumer: program loader or RAM initialiser.

## Interface
- BASE_ADDR, 0: ROM byte address of the first file byte.
- MAX_BYTES, 65536: clamp for the file size read from ROM.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin streaming; sampled only in IDLE
- rom_en  out  1  ROM enable
- rom_address  out  64  ROM byte address
- rom_data  in  64  ROM registered output
- out_valid  out  1  out_data holds a valid byte
- out_ready  in  1  consumer accepts byte
- out_data  out  8  stream byte
- out_last  out  1  qualifies final byte of file
- length  out  32  clamped file size, valid from SIZE_CAP onward
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on completion
- checksum  out  8  modulo-256 sum of accepted bytes (see Configuration)

## Operation
- ROM contract: ROM samples en/address on posedge; rom_data is valid only in the cycle after an enable cycle (ROM outputs 0 when en low). Capture rom_data in exactly that cycle.
- States: IDLE -> SIZE_REQ -> SIZE_CAP -> {FETCH -> LOAD -> EMIT}* -> DONE -> IDLE.
- IDLE: rom_en=0. start=1 -> SIZE_REQ; clear remaining, offset, checksum.
- SIZE_REQ: rom_en=1, rom_address=64'hFFFF_FFFF_FFFF_FFFF. -> SIZE_CAP.
- SIZE_CAP: remaining = min(rom_data, MAX_BYTES); length = same (low 32 bits). remaining==0 -> DONE, else FETCH.
- FETCH: rom_en=1, rom_address=BASE_ADDR+offset (64-bit, wraps). -> LOAD.
- LOAD: load rom_data into unpacker; count = min(8, remaining); offset += 8. -> EMIT.
- EMIT: out_valid=1, out_data=unpacker byte 0 (rom_data[7:0] first). On valid&&ready: shift right 8, count--, remaining--. out_last=1 when remaining==1. When the accepted byte empties the buffer: remaining becomes 0 -> DONE, else FETCH.
- DONE: done=1 for one cycle -> IDLE.
- rom_en=0 in every state not listed as driving it; rom_address holds last value.
- start while busy ignored. out_ready ignored outside EMIT.
- out_data/out_last stable while out_valid && !out_ready.

## Timing
- Reset: state IDLE; rom_en, rom_address, out_valid, out_data, out_last, length, busy, done, checksum all 0.
- Reset mid-stream aborts immediately; no done pulse; next start re-reads size.
- start sampled at edge E0 -> first out_valid in cycle E4..E5 (4 edges later).
- Sustained throughput with out_ready held high: 8 bytes per 10 cycles (8 EMIT + FETCH + LOAD).
- done asserts the cycle after the last byte is accepted; busy falls the cycle after done.
- Size 0: start -> done in 3 edges, no out_valid.

## Configuration
- TC_ROM_STREAMER_CHECKSUM_EN defined: checksum accumulates (checksum + out_data) mod 256 on every accepted byte, cleared on start, held after DONE until next start.
- Undefined: no accumulator logic; checksum tied to 0.

## Structure
- Package tc_rom_streamer_pkg: state enum, ROM_ADDR_W=64, ROM_SIZE_ADDR (all-ones), BYTES_PER_WORD=8.
- Sub-module tc_byte_unpacker: 64-bit load/shift register with 4-bit byte count; ports load, data_in[63:0], count_in, pop, byte_out[7:0], empty.

## Test plan
- File of 3 bytes 0x11,0x22,0x33, ready high -> bytes in order, out_last only on 0x33, length=3, done once, checksum=0x66 (macro on) / 0 (off).
- 20-byte file, ready high -> 3 word fetches at addresses 0, 8, 16; 20 bytes accepted; out_last on byte 20.
- Size slot 0 -> no out_valid; done 3 edges after start; no word fetch.
- Size slot 100000, MAX_BYTES=65536 -> length=65536; final fetch at address 65528.
- Random out_ready stalls on 9-byte file -> out_data stable across stalls; sequence intact; start pulses mid-stream ignored.
- Assert rst during 3rd EMIT byte -> all outputs 0 next cycle, no done; new start restarts with size read at all-ones address.

Source files
------------

// File: rtl/tc_rom_streamer_pkg.sv
// tc_rom_streamer_pkg: shared constants and the sequencer state type for
// tc_rom_streamer and its byte unpacker.
package tc_rom_streamer_pkg;

  localparam int unsigned ROM_ADDR_W = 64;
  // The file size lives in the ROM's all-ones slot.
  localparam logic [ROM_ADDR_W-1:0] ROM_SIZE_ADDR = '1;
  localparam int unsigned BYTES_PER_WORD = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIZE_REQ,
    S_SIZE_CAP,
    S_FETCH,
    S_LOAD,
    S_EMIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/tc_byte_unpacker.sv
// tc_byte_unpacker: 64-bit load/shift register that hands out a word one
// byte at a time, least significant byte first.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       capture data_in and count_in (has priority over pop)
//   data_in    64-bit word to unpack
//   count_in   number of valid bytes in data_in (0..8)
//   pop        consume byte_out
//   byte_out   current byte (word bits [7:0] after previous shifts)
//   empty      no bytes left
//   last       exactly one byte left
module tc_byte_unpacker (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] data_in,
  input  logic [3:0]  count_in,
  input  logic        pop,
  output logic [7:0]  byte_out,
  output logic        empty,
  output logic        last
);

  logic [63:0] data_q;
  logic [3:0]  count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      count_q <= '0;
    end else if (load) begin
      data_q  <= data_in;
      count_q <= count_in;
    end else if (pop && (count_q != 4'd0)) begin
      data_q  <= {8'h00, data_q[63:8]};
      count_q <= count_q - 4'd1;
    end
  end

  assign byte_out = data_q[7:0];
  assign empty    = (count_q == 4'd0);
  assign last     = (count_q == 4'd1);

endmodule

// File: rtl/tc_rom_streamer.sv
// tc_rom_streamer: reads the file size from the ROM's all-ones slot, then
// fetches 64-bit words starting at BASE_ADDR and streams the file as a
// little-endian byte stream over valid/ready.
// Optional feature: define TC_ROM_STREAMER_CHECKSUM_EN to enable the
// modulo-256 checksum of accepted bytes; otherwise checksum is tied to 0.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         begin streaming (sampled only when idle)
//   rom_en        ROM enable
//   rom_address   ROM byte address (holds its last value when not driven)
//   rom_data      ROM registered output, valid the cycle after rom_en
//   out_valid     out_data holds a byte
//   out_ready     consumer accepts the byte
//   out_data      stream byte
//   out_last      final byte of the file
//   length        clamped file size
//   busy          not idle
//   done          one-cycle completion pulse
//   checksum      modulo-256 sum of accepted bytes
module tc_rom_streamer
  import tc_rom_streamer_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter logic [31:0] MAX_BYTES = 32'd65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        rom_en,
  output logic [63:0] rom_address,
  input  logic [63:0] rom_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic [31:0] length,
  output logic        busy,
  output logic        done,
  output logic [7:0]  checksum
);

  state_t      state_q, state_d;
  logic [31:0] remaining_q;
  logic [63:0] offset_q;
  logic [63:0] addr_q;
  logic [31:0] length_q;
  logic [63:0] size_capped;

  logic        unp_load, unp_pop, unp_empty, unp_last;
  logic [3:0]  unp_count;
  logic [7:0]  unp_byte;

  assign size_capped = (rom_data > 64'(MAX_BYTES)) ? 64'(MAX_BYTES) : rom_data;
  assign unp_count   = (remaining_q >= 32'(BYTES_PER_WORD)) ?
                       4'(BYTES_PER_WORD) : remaining_q[3:0];

  tc_byte_unpacker u_unpacker (
    .clk      (clk),
    .rst      (rst),
    .load     (unp_load),
    .data_in  (rom_data),
    .count_in (unp_count),
    .pop      (unp_pop),
    .byte_out (unp_byte),
    .empty    (unp_empty),
    .last     (unp_last)
  );

  always_comb begin
    state_d     = state_q;
    rom_en      = 1'b0;
    rom_address = addr_q;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    done        = 1'b0;
    unp_load    = 1'b0;
    unp_pop     = 1'b0;
    case (state_q)
      S_IDLE:     if (start) state_d = S_SIZE_REQ;
      S_SIZE_REQ: begin
        rom_en      = 1'b1;
        rom_address = ROM_SIZE_ADDR;
        state_d     = S_SIZE_CAP;
      end
      S_SIZE_CAP: state_d = (size_capped == 64'd0) ? S_DONE : S_FETCH;
      S_FETCH: begin
        rom_en      = 1'b1;
        rom_address = BASE_ADDR + offset_q;
        state_d     = S_LOAD;
      end
      S_LOAD: begin
        unp_load = 1'b1;
        state_d  = S_EMIT;
      end
      S_EMIT: begin
        out_valid = 1'b1;
        out_last  = (remaining_q == 32'd1);
        if (out_ready) begin
          unp_pop = 1'b1;
          // Leave on the byte that drains the buffer, not after it.
          if (unp_last || unp_empty)
            state_d = (remaining_q == 32'd1) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      offset_q    <= '0;
      addr_q      <= '0;
      length_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= rom_address;
      case (state_q)
        S_IDLE: if (start) begin
          remaining_q <= '0;
          offset_q    <= '0;
        end
        S_SIZE_CAP: begin
          remaining_q <= size_capped[31:0];
          length_q    <= size_capped[31:0];
        end
        S_LOAD: offset_q <= offset_q + 64'(BYTES_PER_WORD);
        S_EMIT: if (out_ready) remaining_q <= remaining_q - 32'd1;
        default: ;
      endcase
    end
  end

  assign out_data = out_valid ? unp_byte : 8'h00;
  assign length   = length_q;
  assign busy     = (state_q != S_IDLE);

`ifdef TC_ROM_STREAMER_CHECKSUM_EN
  logic [7:0] checksum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      checksum_q <= '0;
    else if ((state_q == S_IDLE) && start)
      checksum_q <= '0;
    else if (unp_pop)
      checksum_q <= checksum_q + unp_byte;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_tc_rom_streamer.sv
// tb_tc_rom_streamer: directed and randomized checks of tc_rom_streamer
// against a byte-array ROM and an index-based expectation of the stream.
module tb_tc_rom_streamer;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic        rom_en, out_valid, out_last, busy, done;
  logic [63:0] rom_address, rom_data;
  logic [7:0]  out_data, checksum;
  logic [31:0] length;

  always #5 clk = ~clk;

  tc_rom_streamer dut (
    .clk(clk), .rst(rst), .start(start),
    .rom_en(rom_en), .rom_address(rom_address), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .length(length), .busy(busy), .done(done),
    .checksum(checksum)
  );

  // ROM model: file bytes at address a are mem[a mod 256]; size in all-ones slot.
  logic [7:0]  mem [256];
  logic [63:0] size_slot;

  function automatic logic [63:0] rom_word(input logic [63:0] a);
    logic [63:0] w;
    if (a == '1) return size_slot;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = mem[8'(a + 64'(i))];
    return w;
  endfunction

  always @(posedge clk) rom_data <= rom_en ? rom_word(rom_address) : 64'd0;

  int cmp_n = 0;
  int err_n = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0]  got_data [$];
  logic        got_last [$];
  logic [63:0] rom_q [$];
  int          done_idx, first_valid, done_cnt;
  logic [31:0] len_seen;

  // One start pulse (edge E0 ends idx 0), then sample each negedge.
  // abort_idx > 0 asserts rst at that negedge and checks the reset values.
  task automatic run(input int abort_idx, input bit rnd_ready, input bit poke);
    bit pv, pr;
    logic [7:0] pd;
    logic pl;
    int idx;
    bit fin;
    got_data.delete(); got_last.delete(); rom_q.delete();
    done_idx = -1; first_valid = -1; done_cnt = 0; pv = 0; pr = 0; pd = '0; pl = 0;
    fin = 0;
    out_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    idx = 0;
    for (int guard = 0; guard < 3000 && !fin; guard++) begin
      @(negedge clk);
      idx++;
      if (pv && !pr) begin
        chk("stall_data_stable", out_data, pd);
        chk("stall_last_stable", out_last, pl);
      end
      if (out_valid && first_valid < 0) first_valid = idx;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      if (rom_en) rom_q.push_back(rom_address);
      if (done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = idx;
      end
      len_seen = length;
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      if (idx == abort_idx) begin
        rst = 1'b1;
        #1;
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_address", rom_address, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_length", length, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_checksum", checksum, 0);
        @(negedge clk);
        chk("rst_no_done", done, 0);
        @(posedge clk); #1 rst = 1'b0;
        fin = 1;
      end else if (done_idx >= 0 && idx == done_idx + 1) begin
        chk("busy_falls_after_done", busy, 0);
        fin = 1;
      end else begin
        @(posedge clk); #1;
        if (rnd_ready) out_ready = 1'($urandom % 2);
        start = (poke && done_idx < 0 && out_valid) ? 1'($urandom % 3 == 0) : 1'b0;
      end
    end
    start = 1'b0;
    if (abort_idx == 0) chk("done_reached", (done_idx >= 0), 1);
  endtask

  // Expected stream: byte k of the file is mem[k mod 256]; one fetch per 8 bytes.
  task automatic check_stream(input string tag, input int n);
    int exp_len;
    int words;
    logic [7:0] sum;
    exp_len = (n > 65536) ? 65536 : n;
    words = (exp_len + 7) / 8;
    sum = 8'h00;
    chk({tag, "_count"}, got_data.size(), exp_len);
    for (int k = 0; k < exp_len && k < got_data.size(); k++) begin
      chk($sformatf("%s_byte%0d", tag, k), got_data[k], mem[k % 256]);
      chk($sformatf("%s_last%0d", tag, k), got_last[k], (k == exp_len - 1));
      sum = sum + mem[k % 256];
    end
    chk({tag, "_length"}, length, exp_len);
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_rom_reads"}, rom_q.size(), 1 + words);
    if (rom_q.size() > 0) chk({tag, "_size_addr"}, rom_q[0], 64'hFFFF_FFFF_FFFF_FFFF);
    for (int w = 0; w < words && w + 1 < rom_q.size(); w++)
      chk($sformatf("%s_fetch%0d", tag, w), rom_q[w + 1], 64'(8 * w));
`ifdef TC_ROM_STREAMER_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, sum);
`else
    chk({tag, "_checksum"}, checksum, 0);
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; size_slot = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rom_en", rom_en, 0);
    chk("reset_rom_address", rom_address, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_length", length, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_checksum", checksum, 0);
    rst = 1'b0;

    // Three-byte file
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    size_slot = 64'd3;
    run(0, 0, 0);
    check_stream("f3", 3);
    chk("f3_first_valid_idx", first_valid, 5);
    chk("f3_done_idx", done_idx, 8);

    // 20 bytes, full throughput
    size_slot = 64'd20;
    run(0, 0, 0);
    check_stream("f20", 20);
    chk("f20_done_idx", done_idx, 29);

    // Empty file
    size_slot = 64'd0;
    run(0, 0, 0);
    chk("f0_done_idx", done_idx, 3);
    chk("f0_no_valid", first_valid, -1);
    chk("f0_only_size_read", rom_q.size(), 1);
    chk("f0_length", length, 0);

    // Oversized file: clamp, then abort after a couple of words
    size_slot = 64'd100000;
    run(20, 0, 0);
    chk("clamp_length", len_seen, 65536);
    chk("clamp_fetch0", rom_q[1], 64'd0);
    chk("clamp_fetch1", rom_q[2], 64'd8);
    for (int k = 0; k + 1 < got_data.size(); k++)
      chk($sformatf("clamp_byte%0d", k), got_data[k], mem[k]);

    // Nine bytes with random stalls and ignored start pulses
    size_slot = 64'd9;
    run(0, 1, 1);
    check_stream("f9", 9);

    // Reset during third byte, then restart
    size_slot = 64'd20;
    run(7, 0, 0);
    chk("abort_bytes_before", got_data.size(), 3);
    chk("abort_byte0", got_data[0], mem[0]);
    chk("abort_byte1", got_data[1], mem[1]);
    size_slot = 64'd5;
    run(0, 0, 0);
    check_stream("restart5", 5);

    // Random sizes with random stalls
    for (int t = 0; t < 4; t++) begin
      int n;
      n = int'($urandom_range(1, 40));
      size_slot = 64'(n);
      run(0, 1, 1);
      check_stream($sformatf("rnd%0d", t), n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
